ara_runtime_monitor: RTL and testbench
======================================

# ara_runtime_monitor

Synthesizable vector-runtime and stall-event monitor for the Ara SoC, instantiated next to the Ara cluster in `ara_system`. It sequences a set of saturating counters from accelerator activity: it arms under a software enable, starts on the first dispatched vector instruction, and stops once Ara has drained. On stop it snapshots the counters into software-readable buffers. It also owns a small register port that the control-register block maps into the memory space.

## Interface
Parameters:
- NrEvents, 3: number of stall-event inputs (0 = D$ miss, 1 = I$ miss, 2 = scoreboard full).
- CntWidth, 64: width of every counter and buffer.
- IdleHoldCycles, 2: consecutive quiet cycles required before a snapshot; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- acc_req_valid_i  in  1  vector instruction dispatched to the cluster.
- ara_idle_i  in  1  cluster 0 reports idle.
- event_i  in  NrEvents  per-cycle stall events.
- reg_req_valid_i  in  1  register access request.
- reg_req_write_i  in  1  1 = write.
- reg_req_addr_i  in  8  byte address, 8-byte aligned.
- reg_req_wdata_i  in  64  write data.
- reg_rsp_valid_o  out  1  response strobe.
- reg_rsp_rdata_o  out  64  read data; 0 on writes and errors.
- reg_rsp_err_o  out  1  access error.
- counting_o  out  1  state is COUNTING.
- snapshot_o  out  1  one-cycle pulse when the buffers update.

Every output resets to 0.

## Operation
Register map (64-bit registers):
- 0x00 CTRL (RW):
  - bit0 EN.
  - bit1 CLEAR: write-1, self-clearing, always reads 0.
  - bit2 ONESHOT.
- 0x08 STATUS (RO):
  - bit0 counting.
  - bit1 snapshot-valid: sticky; cleared by a read of 0x10.
  - [4:2] state encoding.
- 0x10 RUNTIME_BUF (RO).
- 0x18 + 8*i EVENT_BUF[i] (RO).

Register error rules:
- A write to an RO register, or any access to an unmapped address, sets err=1.
- An erroring access has no side effects.

FSM, all transitions on the clock edge:
- IDLE:
  - Live counters hold.
  - EN=1 → ARMED.
- ARMED:
  - acc_req_valid_i=1 → COUNTING.
  - EN=0 → IDLE.
- COUNTING:
  - Runtime counter +1 every cycle.
  - EVENT[i] +1 on each cycle with event_i[i]=1.
  - Quiet counter: increments on cycles with ara_idle_i=1 and acc_req_valid_i=0; any other cycle resets it to 0.
  - When the quiet counter reaches IdleHoldCycles → SNAPSHOT.
  - EN=0 does not stop counting. The drain continues until the snapshot.
- SNAPSHOT (one cycle):
  - Buffers ← live counters.
  - snapshot_o=1; snapshot-valid set.
  - Next state: IDLE if EN=0; DONE if ONESHOT=1; otherwise PAUSED.
- PAUSED:
  - Live counters hold.
  - acc_req_valid_i=1 → COUNTING. Counts accumulate; they are not reset.
  - EN=0 → IDLE.
- DONE:
  - Further requests are ignored.
  - Writing CTRL with EN=0 → IDLE.

Arithmetic and boundary rules:
- All counters saturate at all-ones; they never wrap.
- CLEAR zeroes the live counters and the quiet counter, in any state, without changing the state. Buffers are untouched.
- CLEAR in the same cycle as an increment: the clear wins.
- A register read in the same cycle as a snapshot returns the pre-snapshot buffer value.
- A CTRL write takes effect on the cycle after the write strobe.
- Reset mid-operation: state → IDLE; all counters, buffers and CTRL → 0.

## Timing
- Register port:
  - Single-cycle, always accepting.
  - reg_rsp_valid_o is asserted exactly one cycle after reg_req_valid_i.
  - rdata is registered.
  - Back-to-back requests are allowed.
- Start: with acc_req_valid_i high at cycle t in ARMED, the first runtime increment happens at edge t+2. The count therefore excludes the dispatch cycle.
- Stop: with the quiet condition holding over cycles t..t+IdleHoldCycles-1:
  - The SNAPSHOT state is registered at edge t+IdleHoldCycles.
  - snapshot_o is high during the following cycle.
- counting_o is a registered decode of the state.

## Structure
- Package ara_runtime_monitor_pkg holds:
  - the state enum, 3-bit encoded: IDLE=0, ARMED=1, COUNTING=2, SNAPSHOT=3, PAUSED=4, DONE=5;
  - the register offset constants and CTRL bit positions.
- One sub-module, ara_sat_counter (parameter Width; ports en, clr, q), instantiated 1+NrEvents times.

## Test plan
- Basic run:
  - Stimulus: write EN=1; pulse acc_req_valid for 1 cycle; hold ara_idle=0 for 10 cycles, then 1.
  - Response: RUNTIME_BUF = 10 + IdleHoldCycles = 12; snapshot_o pulses once; STATUS bit1 = 1.
- Events:
  - Stimulus: event_i[0] high on 3 of the counting cycles; event_i[2] high on every counting cycle.
  - Response: EVENT_BUF[0] = 3; EVENT_BUF[2] = RUNTIME_BUF.
- Accumulate and oneshot:
  - Stimulus: two bursts of 5+2 cycles with ONESHOT=0.
  - Response: second RUNTIME_BUF = 14.
  - Stimulus: same with ONESHOT=1.
  - Response: RUNTIME_BUF = 7 and stays 7; state = DONE.
- Disable and clear:
  - Stimulus: EN=0 written mid-COUNTING.
  - Response: counting continues until idle; snapshot taken; state = IDLE.
  - Stimulus: CLEAR during COUNTING at runtime 6.
  - Response: runtime restarts from 0; buffers unchanged.
- Register errors and saturation:
  - Stimulus: write to 0x10; read of 0x40.
  - Response: err=1 for both; state unaffected.
  - Stimulus: force a counter to all-ones − 1, then count 3 cycles.
  - Response: counter = all-ones.
- Reset mid-COUNTING:
  - Stimulus: assert rst_ni low mid-COUNTING.
  - Response: all outputs 0; STATUS reads 0 after release.

Source files
------------

// File: rtl/ara_runtime_monitor_pkg.sv
// Shared types and register layout for the Ara runtime monitor.
// State encoding is software-visible through STATUS[4:2].
package ara_runtime_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMED    = 3'd1,
      ST_COUNTING = 3'd2,
      ST_SNAPSHOT = 3'd3,
      ST_PAUSED   = 3'd4,
      ST_DONE     = 3'd5
   } state_e;

   localparam logic [7:0] REG_CTRL    = 8'h00;
   localparam logic [7:0] REG_STATUS  = 8'h08;
   localparam logic [7:0] REG_RUNTIME = 8'h10;
   localparam logic [7:0] REG_EVENT0  = 8'h18;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_CLEAR   = 1;
   localparam int CTRL_ONESHOT = 2;

endpackage

// File: rtl/ara_sat_counter.sv
// Saturating up-counter: +1 on en, zero on clr (clr wins), sticks at all-ones.
// Updates every cycle; no backpressure.
module ara_sat_counter #(
   parameter int Width = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en,
   input  logic             clr,
   output logic [Width-1:0] q
);

   logic [Width-1:0] r_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (en && (r_q != '1)) begin
         r_q <= r_q + Width'(1);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/ara_runtime_monitor.sv
// Runtime/stall monitor: arms on EN, counts from first dispatch until Ara drains, then snapshots.
// Register port answers every request exactly one cycle later with registered data; never stalls.
module ara_runtime_monitor #(
   parameter int NrEvents       = 3,
   parameter int CntWidth       = 64,
   parameter int IdleHoldCycles = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                acc_req_valid_i,
   input  logic                ara_idle_i,
   input  logic [NrEvents-1:0] event_i,
   input  logic                reg_req_valid_i,
   input  logic                reg_req_write_i,
   input  logic [7:0]          reg_req_addr_i,
   input  logic [63:0]         reg_req_wdata_i,
   output logic                reg_rsp_valid_o,
   output logic [63:0]         reg_rsp_rdata_o,
   output logic                reg_rsp_err_o,
   output logic                counting_o,
   output logic                snapshot_o
);

   import ara_runtime_monitor_pkg::*;

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_en;
   logic                r_oneshot;
   logic                r_snap_vld;
   logic                r_counting;
   logic                r_snapshot;
   logic [3:0]          r_quiet;
   logic                r_rsp_vld;
   logic                r_rsp_err;
   logic [63:0]         r_rsp_rdata;
   logic                w_cnt_en;
   logic                w_quiet_cond;
   logic                w_drained;
   logic                w_clear;
   logic                w_ctrl_wr;
   logic                w_rt_rd;
   logic                w_err;
   logic [63:0]         w_rdata;
   logic [CntWidth-1:0] w_rt_cnt;
   logic [CntWidth-1:0] r_rt_buf;
   logic [CntWidth-1:0] w_ev_cnt [NrEvents];
   logic [CntWidth-1:0] r_ev_buf [NrEvents];
   logic                w_unused;

   assign w_unused = ^reg_req_wdata_i[63:3];

   // Register decode; everything stays zero unless a request is present.
   always_comb begin
      w_rdata   = '0;
      w_err     = 1'b0;
      w_ctrl_wr = 1'b0;
      w_rt_rd   = 1'b0;
      if (reg_req_valid_i) begin
         case (reg_req_addr_i)
            REG_CTRL: begin
               w_ctrl_wr = reg_req_write_i;
               if (!reg_req_write_i) begin
                  w_rdata[CTRL_EN]      = r_en;
                  w_rdata[CTRL_ONESHOT] = r_oneshot;
               end
            end
            REG_STATUS: begin
               if (reg_req_write_i) w_err = 1'b1;
               else w_rdata = {59'd0, r_state, r_snap_vld, r_counting};
            end
            REG_RUNTIME: begin
               if (reg_req_write_i) begin
                  w_err = 1'b1;
               end else begin
                  w_rdata = 64'(r_rt_buf);
                  w_rt_rd = 1'b1;
               end
            end
            default: begin
               w_err = 1'b1;
               for (int i = 0; i < NrEvents; i++) begin
                  if (reg_req_addr_i == 8'(REG_EVENT0 + 8 * i)) begin
                     w_err = reg_req_write_i;
                     if (!reg_req_write_i) w_rdata = 64'(r_ev_buf[i]);
                  end
               end
            end
         endcase
      end
   end

   assign w_clear      = w_ctrl_wr & reg_req_wdata_i[CTRL_CLEAR];
   assign w_cnt_en     = (r_state == ST_COUNTING);
   assign w_quiet_cond = ara_idle_i & ~acc_req_valid_i;
   // Leave on the cycle the quiet run would reach the hold length; a CLEAR restarts the run.
   assign w_drained    = w_cnt_en & w_quiet_cond & ~w_clear &
                         ((r_quiet + 4'd1) == 4'(IdleHoldCycles));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (r_en) w_state_nxt = ST_ARMED;
         end
         ST_ARMED, ST_PAUSED: begin
            if (!r_en)                w_state_nxt = ST_IDLE;
            else if (acc_req_valid_i) w_state_nxt = ST_COUNTING;
         end
         ST_COUNTING: begin
            if (w_drained) w_state_nxt = ST_SNAPSHOT;
         end
         ST_SNAPSHOT: begin
            if (!r_en)          w_state_nxt = ST_IDLE;
            else if (r_oneshot) w_state_nxt = ST_DONE;
            else                w_state_nxt = ST_PAUSED;
         end
         ST_DONE: begin
            if (!r_en) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_counting <= 1'b0;
         r_snapshot <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_counting <= (w_state_nxt == ST_COUNTING);
         r_snapshot <= (w_state_nxt == ST_SNAPSHOT);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_quiet <= '0;
      end else if (w_cnt_en && w_quiet_cond && !w_clear) begin
         r_quiet <= r_quiet + 4'd1;
      end else begin
         r_quiet <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_en      <= 1'b0;
         r_oneshot <= 1'b0;
      end else if (w_ctrl_wr) begin
         r_en      <= reg_req_wdata_i[CTRL_EN];
         r_oneshot <= reg_req_wdata_i[CTRL_ONESHOT];
      end
   end

   // A fresh snapshot outranks a concurrent RUNTIME_BUF read, which still saw the old value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_snap_vld <= 1'b0;
         r_rt_buf   <= '0;
         for (int i = 0; i < NrEvents; i++) r_ev_buf[i] <= '0;
      end else if (r_state == ST_SNAPSHOT) begin
         r_snap_vld <= 1'b1;
         r_rt_buf   <= w_rt_cnt;
         for (int i = 0; i < NrEvents; i++) r_ev_buf[i] <= w_ev_cnt[i];
      end else if (w_rt_rd) begin
         r_snap_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rsp_vld   <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_vld   <= reg_req_valid_i;
         r_rsp_err   <= w_err;
         r_rsp_rdata <= w_rdata;
      end
   end

   ara_sat_counter #(.Width(CntWidth)) u_rt_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en    (w_cnt_en),
      .clr   (w_clear),
      .q     (w_rt_cnt)
   );

   for (genvar g = 0; g < NrEvents; g++) begin : g_ev
      ara_sat_counter #(.Width(CntWidth)) u_ev_cnt (
         .clk_i (clk_i),
         .rst_ni(rst_ni),
         .en    (w_cnt_en & event_i[g]),
         .clr   (w_clear),
         .q     (w_ev_cnt[g])
      );
   end

   assign reg_rsp_valid_o = r_rsp_vld;
   assign reg_rsp_rdata_o = r_rsp_rdata;
   assign reg_rsp_err_o   = r_rsp_err;
   assign counting_o      = r_counting;
   assign snapshot_o      = r_snapshot;

endmodule

// File: tb/tb_ara_runtime_monitor.sv
// Bench for ara_runtime_monitor: a full-width instance plus a 4-bit-counter instance sharing stimulus,
// checked against run-length arithmetic (runtime = busy + hold cycles, events = sums of driven bits).
module tb_ara_runtime_monitor;

   localparam int H  = 2;
   localparam int NE = 3;

   logic          clk_i           = 1'b0;
   logic          rst_ni          = 1'b0;
   logic          acc_req_valid_i = 1'b0;
   logic          ara_idle_i      = 1'b1;
   logic [NE-1:0] event_i         = '0;
   logic          reg_req_valid_i = 1'b0;
   logic          reg_req_write_i = 1'b0;
   logic [7:0]    reg_req_addr_i  = '0;
   logic [63:0]   reg_req_wdata_i = '0;

   logic        a_vld, a_err, a_cnt, a_snap;
   logic        b_vld, b_err, b_cnt, b_snap;
   logic [63:0] a_rdata, b_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   // Live and buffered totals as software would expect them (unsaturated).
   int m_rt, b_rt;
   int m_ev [NE];
   int b_ev [NE];

   always #5 clk_i = ~clk_i;

   ara_runtime_monitor #(.NrEvents(NE), .CntWidth(64), .IdleHoldCycles(H)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .acc_req_valid_i(acc_req_valid_i), .ara_idle_i(ara_idle_i),
      .event_i(event_i), .reg_req_valid_i(reg_req_valid_i), .reg_req_write_i(reg_req_write_i),
      .reg_req_addr_i(reg_req_addr_i), .reg_req_wdata_i(reg_req_wdata_i),
      .reg_rsp_valid_o(a_vld), .reg_rsp_rdata_o(a_rdata), .reg_rsp_err_o(a_err),
      .counting_o(a_cnt), .snapshot_o(a_snap));

   ara_runtime_monitor #(.NrEvents(NE), .CntWidth(4), .IdleHoldCycles(H)) u_sat (
      .clk_i(clk_i), .rst_ni(rst_ni), .acc_req_valid_i(acc_req_valid_i), .ara_idle_i(ara_idle_i),
      .event_i(event_i), .reg_req_valid_i(reg_req_valid_i), .reg_req_write_i(reg_req_write_i),
      .reg_req_addr_i(reg_req_addr_i), .reg_req_wdata_i(reg_req_wdata_i),
      .reg_rsp_valid_o(b_vld), .reg_rsp_rdata_o(b_rdata), .reg_rsp_err_o(b_err),
      .counting_o(b_cnt), .snapshot_o(b_snap));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sat4(input int x);
      return (x > 15) ? 64'd15 : 64'(x);
   endfunction

   function automatic logic [63:0] status(input int s, input bit sv);
      return {59'd0, 3'(s), sv, 1'b0};
   endfunction

   task automatic reg_acc(input logic wr, input logic [7:0] addr, input logic [63:0] wd,
                          input logic exp_err, input logic [63:0] exp_a, input logic [63:0] exp_b,
                          input string tag);
      @(negedge clk_i);
      reg_req_valid_i = 1'b1;
      reg_req_write_i = wr;
      reg_req_addr_i  = addr;
      reg_req_wdata_i = wd;
      @(posedge clk_i);
      #1;
      reg_req_valid_i = 1'b0;
      reg_req_write_i = 1'b0;
      check({tag, ".vld"}, 64'(a_vld), 64'd1);
      check({tag, ".err"}, 64'(a_err), 64'(exp_err));
      check({tag, ".dat"}, a_rdata, exp_a);
      check({tag, ".sat"}, b_rdata, exp_b);
   endtask

   task automatic rd(input logic [7:0] addr, input logic [63:0] ea, input logic [63:0] eb, input string tag);
      reg_acc(1'b0, addr, 64'd0, 1'b0, ea, eb, tag);
   endtask

   task automatic wr_ctrl(input logic [63:0] d, input string tag);
      reg_acc(1'b1, 8'h00, d, 1'b0, 64'd0, 64'd0, tag);
      if (d[1]) begin
         m_rt = 0;
         for (int i = 0; i < NE; i++) m_ev[i] = 0;
      end
      @(posedge clk_i);
   endtask

   task automatic rd_bufs(input string tag);
      rd(8'h10, 64'(b_rt), sat4(b_rt), {tag, ".rt"});
      for (int i = 0; i < NE; i++)
         rd(8'h18 + 8'(8 * i), 64'(b_ev[i]), sat4(b_ev[i]), $sformatf("%s.ev%0d", tag, i));
   endtask

   // Dispatch at cycle 0, Ara busy for n cycles, then quiet; optional CTRL write at cycle wr_cyc.
   task automatic burst(input int n, input bit directed, input int wr_cyc, input logic [63:0] wr_dat);
      logic [NE-1:0] ev;
      int last;
      bit clr;
      last = n + H;
      clr  = (wr_cyc >= 0) && wr_dat[1];
      for (int c = 0; c <= last; c++) begin
         @(negedge clk_i);
         if (c == 0) check("cnt_before_start", 64'(a_cnt), 64'd0);
         if (c == 1) check("cnt_after_dispatch", 64'(a_cnt), 64'd1);
         acc_req_valid_i = (c == 0);
         ara_idle_i      = (c == 0) || (c > n);
         if (c == 0)        ev = '0;
         else if (directed) ev = {1'b1, 1'b0, (c == 2 || c == 4 || c == 6)};
         else               ev = 3'($urandom);
         event_i         = ev;
         reg_req_valid_i = (c == wr_cyc);
         reg_req_write_i = (c == wr_cyc);
         reg_req_addr_i  = 8'h00;
         reg_req_wdata_i = wr_dat;
         if (clr && c == wr_cyc) begin
            m_rt = 0;
            for (int i = 0; i < NE; i++) m_ev[i] = 0;
         end else if (c >= 1) begin
            m_rt++;
            for (int i = 0; i < NE; i++) m_ev[i] += int'(ev[i]);
         end
      end
      @(posedge clk_i);
      #1;
      check("snap_rise", 64'(a_snap), 64'd1);
      check("snap_rise_sat", 64'(b_snap), 64'd1);
      @(negedge clk_i);
      event_i         = '1;
      ara_idle_i      = 1'b1;
      reg_req_valid_i = 1'b1;
      reg_req_write_i = 1'b0;
      reg_req_addr_i  = 8'h10;
      @(posedge clk_i);
      #1;
      reg_req_valid_i = 1'b0;
      event_i         = '0;
      check("snap_cycle_read_old", a_rdata, 64'(b_rt));
      check("snap_cycle_read_old_sat", b_rdata, sat4(b_rt));
      check("snap_single_pulse", 64'(a_snap), 64'd0);
      b_rt = m_rt;
      b_ev = m_ev;
   endtask

   initial begin
      m_rt = 0;
      b_rt = 0;
      for (int i = 0; i < NE; i++) begin
         m_ev[i] = 0;
         b_ev[i] = 0;
      end

      // Reset state
      repeat (3) @(negedge clk_i);
      check("reset_flags", 64'({a_vld, a_err, a_cnt, a_snap, b_vld, b_err, b_cnt, b_snap}), 64'd0);
      check("reset_rdata", a_rdata | b_rdata, 64'd0);
      rst_ni = 1'b1;
      rd(8'h08, 64'd0, 64'd0, "status_reset");
      @(posedge clk_i);
      #1;
      check("rsp_one_cycle", 64'(a_vld), 64'd0);
      rd(8'h00, 64'd0, 64'd0, "ctrl_reset");

      // EN lands the cycle after the write strobe
      reg_acc(1'b1, 8'h00, 64'd1, 1'b0, 64'd0, 64'd0, "wr_en");
      rd(8'h08, status(0, 0), status(0, 0), "status_en_lag");
      rd(8'h08, status(1, 0), status(1, 0), "status_armed");
      rd(8'h00, 64'd1, 64'd1, "ctrl_rd");

      // Basic run: 10 busy cycles
      burst(10, 1'b0, -1, 64'd0);
      check("basic_rt_12", 64'(b_rt), 64'd12);
      rd(8'h08, status(4, 1), status(4, 1), "status_snapvld");
      rd_bufs("basic");
      rd(8'h08, status(4, 0), status(4, 0), "status_snapvld_clr");

      // Directed events
      wr_ctrl(64'd3, "clr_ev");
      burst(6, 1'b1, -1, 64'd0);
      rd_bufs("events");
      rd(8'h28, 64'(b_rt), sat4(b_rt), "ev2_eq_rt");
      check("ev0_3", 64'(b_ev[0]), 64'd3);

      // Accumulate across two bursts
      wr_ctrl(64'd3, "clr_acc");
      burst(5, 1'b0, -1, 64'd0);
      rd(8'h10, 64'd7, 64'd7, "acc_first");
      burst(5, 1'b0, -1, 64'd0);
      rd(8'h10, 64'd14, 64'd14, "acc_second");
      rd_bufs("acc");

      // Oneshot: DONE ignores later dispatches
      wr_ctrl(64'd7, "oneshot");
      burst(5, 1'b0, -1, 64'd0);
      rd(8'h08, status(5, 1), status(5, 1), "status_done");
      @(negedge clk_i);
      acc_req_valid_i = 1'b1;
      ara_idle_i      = 1'b0;
      repeat (4) @(negedge clk_i);
      check("done_no_count", 64'(a_cnt), 64'd0);
      acc_req_valid_i = 1'b0;
      ara_idle_i      = 1'b1;
      repeat (4) @(negedge clk_i);
      check("done_no_snap", 64'(a_snap), 64'd0);
      rd(8'h10, 64'd7, 64'd7, "oneshot_rt_stays");
      rd(8'h08, status(5, 0), status(5, 0), "status_done2");
      wr_ctrl(64'd0, "disable_done");
      rd(8'h08, status(0, 0), status(0, 0), "status_idle");

      // EN=0 mid-run: drain and snapshot, then IDLE
      wr_ctrl(64'd3, "clr_dis");
      burst(8, 1'b0, 3, 64'd0);
      rd(8'h08, status(0, 1), status(0, 1), "status_dis_idle");
      rd_bufs("disable");

      // CLEAR at live runtime 6
      wr_ctrl(64'd3, "clr_mid");
      burst(10, 1'b0, 7, 64'd3);
      check("clear_rt_5", 64'(b_rt), 64'd5);
      rd_bufs("clear");

      // Register errors have no side effects
      reg_acc(1'b1, 8'h10, 64'hffff, 1'b1, 64'd0, 64'd0, "err_wr_rt");
      reg_acc(1'b0, 8'h40, 64'd0, 1'b1, 64'd0, 64'd0, "err_rd_40");
      reg_acc(1'b1, 8'h08, 64'hff, 1'b1, 64'd0, 64'd0, "err_wr_status");
      reg_acc(1'b0, 8'h0c, 64'd0, 1'b1, 64'd0, 64'd0, "err_unaligned");
      reg_acc(1'b1, 8'h20, 64'h1, 1'b1, 64'd0, 64'd0, "err_wr_ev");
      rd(8'h08, status(4, 0), status(4, 0), "status_after_err");
      rd(8'h10, 64'(b_rt), sat4(b_rt), "rt_after_err");

      // Random accumulating bursts
      wr_ctrl(64'd3, "clr_rand");
      for (int k = 0; k < 3; k++) burst($urandom_range(1, 12), 1'b0, -1, 64'd0);
      rd_bufs("rand");

      // Saturation on the 4-bit instance
      wr_ctrl(64'd3, "clr_sat");
      burst(20, 1'b1, -1, 64'd0);
      rd_bufs("saturate");
      check("sat_rt_allones", b_rdata, 64'd15);

      // Reset mid-COUNTING
      @(negedge clk_i);
      acc_req_valid_i = 1'b1;
      @(negedge clk_i);
      acc_req_valid_i = 1'b0;
      ara_idle_i      = 1'b0;
      repeat (4) @(negedge clk_i);
      check("counting_before_rst", 64'(a_cnt), 64'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("rst_mid_flags", 64'({a_vld, a_err, a_cnt, a_snap, b_vld, b_err, b_cnt, b_snap}), 64'd0);
      check("rst_mid_rdata", a_rdata | b_rdata, 64'd0);
      @(negedge clk_i);
      ara_idle_i = 1'b1;
      rst_ni     = 1'b1;
      rd(8'h08, 64'd0, 64'd0, "status_after_rst");
      rd(8'h00, 64'd0, 64'd0, "ctrl_after_rst");
      rd(8'h10, 64'd0, 64'd0, "rt_after_rst");
      rd(8'h28, 64'd0, 64'd0, "ev2_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
